// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Package     : mem_arb_pkg
// Description : Shared types and default widths for the I/D memory arbiter.
//               arb_state_t - transaction FSM states
//               req_id_t    - requester identity (I-cache / D-cache)
// Config      : MEM_ARB_DPRIO_EN (see rr_arb2) - fixed D priority when defined
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

  localparam int DEF_REQ_W  = 64;
  localparam int DEF_TAG_W  = 13;
  localparam int DEF_DATA_W = 512;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_RESP = 2'd2,
    DELIVER   = 2'd3
  } arb_state_t;

  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } req_id_t;

endpackage : mem_arb_pkg
`default_nettype wire

// File: rtl/mod_mem_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb2
// Description : Combinational two-way arbiter pick.
//               Round-robin: on a tie the requester that was NOT granted last
//               wins; a single requester always wins.
//               With MEM_ARB_DPRIO_EN defined: D wins whenever it requests,
//               last_i is ignored.
// Ports       : req_i[1:0]     in  request vector (bit0 = I, bit1 = D)
//               last_i         in  requester granted most recently
//               grant_valid_o  out at least one request present
//               grant_id_o     out winning requester
// Config      : MEM_ARB_DPRIO_EN
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  req_id_t    last_i,
  output logic       grant_valid_o,
  output req_id_t    grant_id_o
);

  assign grant_valid_o = |req_i;

`ifdef MEM_ARB_DPRIO_EN
  logic unused_last;
  assign unused_last = last_i;
  assign grant_id_o  = req_i[1] ? REQ_D : REQ_I;
`else
  always_comb begin
    grant_id_o = REQ_I;
    if (req_i[0] && req_i[1]) begin
      // Tie: hand the bus to whoever did not have it last time.
      grant_id_o = (last_i == REQ_I) ? REQ_D : REQ_I;
    end else if (req_i[1]) begin
      grant_id_o = REQ_D;
    end
  end
`endif

endmodule : rr_arb2
`default_nettype wire

// File: rtl/mod_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mod_mem_arbiter
// Description : Shares one memory request/response bus between the L1
//               I-cache (i_*) and the L1 D-cache (d_*). One transaction in
//               flight at a time; the response is routed back to the granted
//               requester (owner).
//               IDLE -> ISSUE -> WAIT_RESP -> DELIVER -> IDLE
// Ports       : clk, reset (async, active-low)
//               i_/d_ reqcyc, req, reqtag (in)  ; reqack (out, grant pulse)
//               i_/d_ respcyc, resp, resptag (out) ; respack (in)
//               m_reqcyc, m_req, m_reqtag (out) ; m_reqack (in)
//               m_respcyc, m_resp, m_resptag (in) ; m_respack (out)
// Config      : MEM_ARB_DPRIO_EN - fixed D priority instead of round-robin
// Revision    : 1.0 - initial release
// ============================================================================
module mod_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int REQ_W  = DEF_REQ_W,
  parameter int TAG_W  = DEF_TAG_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              i_reqcyc,
  input  logic [REQ_W-1:0]  i_req,
  input  logic [TAG_W-1:0]  i_reqtag,
  output logic              i_reqack,
  output logic              i_respcyc,
  output logic [DATA_W-1:0] i_resp,
  output logic [TAG_W-1:0]  i_resptag,
  input  logic              i_respack,

  input  logic              d_reqcyc,
  input  logic [REQ_W-1:0]  d_req,
  input  logic [TAG_W-1:0]  d_reqtag,
  output logic              d_reqack,
  output logic              d_respcyc,
  output logic [DATA_W-1:0] d_resp,
  output logic [TAG_W-1:0]  d_resptag,
  input  logic              d_respack,

  output logic              m_reqcyc,
  output logic [REQ_W-1:0]  m_req,
  output logic [TAG_W-1:0]  m_reqtag,
  input  logic              m_reqack,
  input  logic              m_respcyc,
  input  logic [DATA_W-1:0] m_resp,
  input  logic [TAG_W-1:0]  m_resptag,
  output logic              m_respack
);

  arb_state_t        state_q,     state_d;
  req_id_t           owner_q,     owner_d;
  req_id_t           last_q,      last_d;
  logic [REQ_W-1:0]  m_req_q,     m_req_d;
  logic [TAG_W-1:0]  m_reqtag_q,  m_reqtag_d;
  logic [DATA_W-1:0] i_resp_q,    i_resp_d;
  logic [TAG_W-1:0]  i_resptag_q, i_resptag_d;
  logic [DATA_W-1:0] d_resp_q,    d_resp_d;
  logic [TAG_W-1:0]  d_resptag_q, d_resptag_d;

  logic    gnt_valid;
  req_id_t gnt_id;
  logic    owner_respack;
  logic    grant_now;

  rr_arb2 u_rr_arb2 (
    .req_i         ({d_reqcyc, i_reqcyc}),
    .last_i        (last_q),
    .grant_valid_o (gnt_valid),
    .grant_id_o    (gnt_id)
  );

  // The grant is taken combinationally in IDLE; gating with reset keeps the
  // ack pulses low while reset is held even though the FSM sits in IDLE.
  assign grant_now     = reset && (state_q == IDLE) && gnt_valid;
  assign owner_respack = (owner_q == REQ_D) ? d_respack : i_respack;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    m_req_d     = m_req_q;
    m_reqtag_d  = m_reqtag_q;
    i_resp_d    = i_resp_q;
    i_resptag_d = i_resptag_q;
    d_resp_d    = d_resp_q;
    d_resptag_d = d_resptag_q;
    case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          owner_d    = gnt_id;
          last_d     = gnt_id;
          m_req_d    = (gnt_id == REQ_D) ? d_req    : i_req;
          m_reqtag_d = (gnt_id == REQ_D) ? d_reqtag : i_reqtag;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        // m_respcyc is deliberately not looked at here: memory must hold it
        // until we reach WAIT_RESP.
        if (m_reqack) begin
          state_d = WAIT_RESP;
        end
      end
      WAIT_RESP: begin
        if (m_respcyc) begin
          if (owner_q == REQ_D) begin
            d_resp_d    = m_resp;
            d_resptag_d = m_resptag;
          end else begin
            i_resp_d    = m_resp;
            i_resptag_d = m_resptag;
          end
          state_d = DELIVER;
        end
      end
      DELIVER: begin
        if (owner_respack) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      owner_q     <= REQ_I;
      last_q      <= REQ_D;  // first tie after reset goes to I
      m_req_q     <= '0;
      m_reqtag_q  <= '0;
      i_resp_q    <= '0;
      i_resptag_q <= '0;
      d_resp_q    <= '0;
      d_resptag_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      m_req_q     <= m_req_d;
      m_reqtag_q  <= m_reqtag_d;
      i_resp_q    <= i_resp_d;
      i_resptag_q <= i_resptag_d;
      d_resp_q    <= d_resp_d;
      d_resptag_q <= d_resptag_d;
    end
  end

  assign i_reqack  = grant_now && (gnt_id == REQ_I);
  assign d_reqack  = grant_now && (gnt_id == REQ_D);

  assign m_reqcyc  = (state_q == ISSUE);
  assign m_req     = m_req_q;
  assign m_reqtag  = m_reqtag_q;
  assign m_respack = m_respcyc && (state_q == WAIT_RESP);

  assign i_respcyc = (state_q == DELIVER) && (owner_q == REQ_I);
  assign i_resp    = i_resp_q;
  assign i_resptag = i_resptag_q;
  assign d_respcyc = (state_q == DELIVER) && (owner_q == REQ_D);
  assign d_resp    = d_resp_q;
  assign d_resptag = d_resptag_q;

endmodule : mod_mem_arbiter
`default_nettype wire

// File: tb/tb_mod_mem_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_mod_mem_arbiter
// Description : Directed self-checking bench for mod_mem_arbiter.
//               Inputs change 2 ns after posedge, outputs sampled 2-4 ns after.
// Config      : MEM_ARB_DPRIO_EN changes the expected grant order
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mod_mem_arbiter;

  localparam int REQ_W  = 64;
  localparam int TAG_W  = 13;
  localparam int DATA_W = 512;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              i_reqcyc = 1'b0, d_reqcyc = 1'b0;
  logic [REQ_W-1:0]  i_req = '0, d_req = '0;
  logic [TAG_W-1:0]  i_reqtag = '0, d_reqtag = '0;
  logic              i_reqack, d_reqack, i_respcyc, d_respcyc;
  logic [DATA_W-1:0] i_resp, d_resp;
  logic [TAG_W-1:0]  i_resptag, d_resptag;
  logic              i_respack = 1'b0, d_respack = 1'b0;
  logic              m_reqcyc, m_respack;
  logic [REQ_W-1:0]  m_req;
  logic [TAG_W-1:0]  m_reqtag;
  logic              m_reqack = 1'b0, m_respcyc = 1'b0;
  logic [DATA_W-1:0] m_resp = '0;
  logic [TAG_W-1:0]  m_resptag = '0;

  int n_checks = 0;
  int n_pass   = 0;

  mod_mem_arbiter #(.REQ_W(REQ_W), .TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset),
    .i_reqcyc(i_reqcyc), .i_req(i_req), .i_reqtag(i_reqtag), .i_reqack(i_reqack),
    .i_respcyc(i_respcyc), .i_resp(i_resp), .i_resptag(i_resptag), .i_respack(i_respack),
    .d_reqcyc(d_reqcyc), .d_req(d_req), .d_reqtag(d_reqtag), .d_reqack(d_reqack),
    .d_respcyc(d_respcyc), .d_resp(d_resp), .d_resptag(d_resptag), .d_respack(d_respack),
    .m_reqcyc(m_reqcyc), .m_req(m_req), .m_reqtag(m_reqtag), .m_reqack(m_reqack),
    .m_respcyc(m_respcyc), .m_resp(m_resp), .m_resptag(m_resptag), .m_respack(m_respack)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Plays the memory side of one transaction and checks the delivery.
  // Returns in the first DELIVER cycle.
  task automatic serve(input logic exp_d, input logic [REQ_W-1:0] exp_req,
                       input logic [TAG_W-1:0] exp_tag, input logic [DATA_W-1:0] data,
                       input logic [TAG_W-1:0] rtag, input int ack_dly);
    int n = 0;
    while (m_reqcyc !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("serve_reqcyc_seen", m_reqcyc, 1);
    chk("serve_m_req", m_req, exp_req);
    chk("serve_m_reqtag", m_reqtag, exp_tag);
    repeat (ack_dly) tick();
    chk("serve_reqcyc_held", m_reqcyc, 1);
    m_reqack = 1'b1;
    tick();
    m_reqack  = 1'b0;
    chk("serve_reqcyc_dropped", m_reqcyc, 0);
    m_respcyc = 1'b1;
    m_resp    = data;
    m_resptag = rtag;
    #1;
    chk("serve_m_respack", m_respack, 1);
    tick();
    m_respcyc = 1'b0;
    m_resp    = '0;
    #1;
    chk("serve_i_respcyc", i_respcyc, !exp_d);
    chk("serve_d_respcyc", d_respcyc, exp_d);
    chk("serve_resp", exp_d ? d_resp : i_resp, data);
    chk("serve_resptag", exp_d ? d_resptag : i_resptag, rtag);
  endtask

  initial begin
    logic [DATA_W-1:0] blk;
    logic              exp_d;

    // ---- reset, then I-only transaction --------------------------------
    i_reqcyc = 1'b1; i_req = 64'h1000; i_reqtag = 13'd5;
    i_respack = 1'b1; d_respack = 1'b1;
    tick(); tick();
    #1;
    chk("rst_i_reqack", i_reqack, 0);
    chk("rst_m_reqcyc", m_reqcyc, 0);
    chk("rst_respcyc", {i_respcyc, d_respcyc}, 0);
    chk("rst_m_req", m_req, 0);
    chk("rst_i_resp", i_resp, 0);
    reset = 1'b1;
    #1;
    chk("t1_i_reqack", i_reqack, 1);
    chk("t1_d_reqack", d_reqack, 0);
    tick();
    i_reqcyc = 1'b0;
    #1;
    chk("t1_ack_one_cycle", i_reqack, 0);
    blk = {64{8'hA5}};
    serve(1'b0, 64'h1000, 13'd5, blk, 13'd5, 2);
    tick();
    #1;
    chk("t1_respcyc_done", {i_respcyc, d_respcyc}, 0);

    // ---- both requesting continuously: alternation ----------------------
    reset = 1'b0;
    tick();
    reset = 1'b1;
    i_reqcyc = 1'b1; i_req = 64'h2000; i_reqtag = 13'd1;
    d_reqcyc = 1'b1; d_req = 64'h3000; d_reqtag = 13'd2;
    #1;
`ifdef MEM_ARB_DPRIO_EN
    chk("t2_first_grant_d", d_reqack, 1);
`else
    chk("t2_first_grant_i", i_reqack, 1);
`endif
    for (int k = 0; k < 6; k++) begin
`ifdef MEM_ARB_DPRIO_EN
      exp_d = 1'b1;
`else
      exp_d = k[0];
`endif
      blk = {16{32'hC0DE0000 | 32'(k)}};
      serve(exp_d, exp_d ? 64'h3000 : 64'h2000, exp_d ? 13'd2 : 13'd1,
            blk, 13'(16 + k), 0);
    end
    i_reqcyc = 1'b0;
    d_reqcyc = 1'b0;
    tick();
    tick();

    // ---- owner delays respack; D waits ----------------------------------
    i_respack = 1'b0;
    i_reqcyc = 1'b1; i_req = 64'h4000; i_reqtag = 13'd7;
    #1;
    chk("t4_i_reqack", i_reqack, 1);
    tick();
    i_reqcyc = 1'b0;
    d_reqcyc = 1'b1; d_req = 64'h5000; d_reqtag = 13'd9;
    blk = {8{64'hDEAD_BEEF_0123_4567}};
    serve(1'b0, 64'h4000, 13'd7, blk, 13'd7, 1);
    for (int c = 2; c <= 5; c++) begin
      tick();
      #1;
      chk("t4_respcyc_held", i_respcyc, 1);
      chk("t4_resp_stable", i_resp, blk);
      chk("t4_tag_stable", i_resptag, 7);
      chk("t4_no_m_reqcyc", {m_reqcyc, d_reqack}, 0);
    end
    i_respack = 1'b1;
    tick();
    #1;
    chk("t4_respcyc_drop", i_respcyc, 0);
    chk("t4_next_grant", d_reqack, 1);
    tick();
    d_reqcyc = 1'b0;
    blk = {16{32'h5A5A_0F0F}};
    serve(1'b1, 64'h5000, 13'd9, blk, 13'd9, 0);
    tick();

    // ---- m_respcyc during ISSUE is ignored ------------------------------
    d_reqcyc = 1'b1; d_req = 64'h6000; d_reqtag = 13'd3;
    #1;
    chk("t5_d_reqack", d_reqack, 1);
    tick();
    d_reqcyc  = 1'b0;
    blk = {32{16'h1234}};
    m_respcyc = 1'b1; m_resp = blk; m_resptag = 13'd3;
    #1;
    chk("t5_issue_reqcyc", m_reqcyc, 1);
    chk("t5_issue_respack", m_respack, 0);
    tick();
    #1;
    chk("t5_no_delivery", d_respcyc, 0);
    chk("t5_still_issue", m_reqcyc, 1);
    m_reqack = 1'b1;
    #1;
    chk("t5_ack_and_resp_respack", m_respack, 0);
    tick();
    m_reqack = 1'b0;
    #1;
    chk("t5_wait_reqcyc", m_reqcyc, 0);
    chk("t5_wait_respack", m_respack, 1);
    chk("t5_wait_no_delivery", d_respcyc, 0);
    tick();
    m_respcyc = 1'b0;
    #1;
    chk("t5_deliver", d_respcyc, 1);
    chk("t5_resp", d_resp, blk);
    chk("t5_resptag", d_resptag, 3);
    tick();

    // ---- reset in WAIT_RESP ---------------------------------------------
    i_reqcyc = 1'b1; i_req = 64'h7000; i_reqtag = 13'd4;
    tick();
    i_reqcyc = 1'b0;
    tick();
    m_reqack = 1'b1;
    tick();
    m_reqack  = 1'b0;
    m_respcyc = 1'b1; m_resp = {DATA_W{1'b1}}; m_resptag = 13'd4;
    #1;
    chk("t6_in_wait", m_respack, 1);
    reset = 1'b0;
    #1;
    chk("t6_rst_respack", m_respack, 0);
    chk("t6_rst_reqcyc", m_reqcyc, 0);
    chk("t6_rst_respcyc", {i_respcyc, d_respcyc}, 0);
    chk("t6_rst_m_req", m_req, 0);
    chk("t6_rst_i_resp", i_resp, 0);
    tick();
    m_respcyc = 1'b0; m_resp = '0; m_resptag = '0;
    reset = 1'b1;
    d_reqcyc = 1'b1; d_req = 64'h8000; d_reqtag = 13'd6;
    #1;
    chk("t6_d_reqack", d_reqack, 1);
    tick();
    d_reqcyc = 1'b0;
    blk = {4{128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF}};
    serve(1'b1, 64'h8000, 13'd6, blk, 13'd6, 1);
    tick();
    #1;
    chk("t6_done", d_respcyc, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_mod_mem_arbiter
`default_nettype wire
